mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL declare parameter A_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: i_a  in  A_WIDTH  instruction-side address; i_strobe  in  1  instruction request; i_din  out  32  read data; i_ready  out  1  instruction transfer done.
REQ-004 SHALL have ports: d_a  in  A_WIDTH  data-side address; d_dout  in  32  write data; d_wen  in  4  byte enables; d_size  in  2  access size; d_rw  in  1  0 read / 1 write; d_strobe  in  1  data request; d_din  out  32  read data; d_ready  out  1  data transfer done.
REQ-005 SHALL have ports: m_a  out  A_WIDTH; m_din  out  32  write data; m_wen  out  4; m_size  out  2; m_rw  out  1; m_strobe  out  1; m_dout  in  32  read data; m_ready  in  1  memory transfer done.

Function
REQ-006 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-007 IDLE: strobe high on one side only -> that side's GRANT state next cycle; both high -> winner per REQ-013; neither -> stay in IDLE.
REQ-008 On the IDLE->GRANT transition, SHALL latch the winner's a/dout/wen/size/rw into request registers.
- Instruction side latches rw=0, wen=4'b0000, size=2'b10.
REQ-009 In GRANT_x, SHALL drive m_strobe=1 and all m_* fields from the request registers only; in IDLE, m_strobe=0 and m_* hold their last values.
REQ-010 In GRANT_x with m_ready=1:
- x_ready=1 for that cycle only if x_strobe is still high.
- x_din=m_dout combinationally.
- Next state is IDLE.
REQ-011 Timing: a request is granted 1 cycle after strobe is seen in IDLE. Completion takes m_ready latency plus 1 IDLE cycle before the next grant. Back-to-back grants without an IDLE cycle are not allowed.
REQ-012 A granted transaction SHALL NOT be aborted.
- If the requester drops its strobe mid-grant, the bus access still completes and its ready is suppressed.
- The other side's ready SHALL never assert during a grant it does not own.
REQ-013 Default arbitration is fixed priority, data over instruction.
REQ-014 i_din and d_din SHALL be 0 whenever their ready is low.
REQ-015 A strobe arriving during a grant SHALL be evaluated only on return to IDLE. It is not queued.

Reset
REQ-016 When rst=1 at a clock edge, SHALL enter IDLE and clear the request registers to 0.
- Outputs: m_strobe=0, i_ready=0, d_ready=0; last_grant (REQ-018) = instruction.
REQ-017 Reset during GRANT_x SHALL abandon the transaction with no ready pulse. The memory side must tolerate the dropped strobe.

Configuration
REQ-018 Macro ARB_ROUND_ROBIN_EN, defined: SHALL keep a 1-bit last_grant register, updated on every completed grant. When both sides request in IDLE, the side not equal to last_grant wins.
REQ-019 ARB_ROUND_ROBIN_EN undefined: last_grant SHALL NOT exist and REQ-013 applies unconditionally.

Structure
REQ-020 State encodings (IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2) and the instruction-side size constant SHALL live in the shared compile_options header/package.
REQ-021 A single sub-module, arb_req_reg, SHALL hold the latched request fields with a load enable. The FSM and muxing stay in the top.

Verification
REQ-022 Instruction only: i_strobe=1, i_a=0x1FC0_0000, m_ready after 3 cycles with m_dout=0x2402_0001 -> m_a=0x1FC0_0000, m_rw=0, i_ready=1 for one cycle with i_din=0x2402_0001, d_ready stays 0.
REQ-023 Simultaneous read: both strobes rise together, d_a=0x0000_0100, i_a=0x0000_0200, round robin off -> d served first. Then after one IDLE cycle i is served, m_a=0x200.
REQ-024 Round robin on, both requesting continuously for 4 transactions -> grant order D,I,D,I; no starvation.
REQ-025 Data write: d_rw=1, d_wen=4'b0011, d_dout=0xDEAD_BEEF, d_size=2'b01 -> m_rw=1, m_wen=4'b0011, m_din=0xDEAD_BEEF, m_size=2'b01 held stable until m_ready, then d_ready=1.
REQ-026 i_strobe dropped mid-grant, and rst asserted mid-grant -> the strobe drop completes the bus access with i_ready=0; rst gives IDLE, m_strobe=0 on the next cycle, no ready pulse.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter:
// FSM state encodings, instruction-side request constants and arbitration helpers.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  // Instruction fetches are always word-sized reads with no byte enables.
  localparam logic [1:0] I_SIZE = 2'b10;
  localparam logic [3:0] I_WEN  = 4'b0000;
  localparam logic       I_RW   = 1'b0;

  localparam logic GRANT_SIDE_I = 1'b0;
  localparam logic GRANT_SIDE_D = 1'b1;

  // Returns 1 when the data side wins; prefer_i only matters on a tie.
  function automatic logic pick_data(input logic i_req, input logic d_req,
                                     input logic prefer_i);
    if (i_req && d_req) begin
      pick_data = ~prefer_i;
    end else begin
      pick_data = d_req;
    end
  endfunction

  function automatic logic [31:0] gate_data(input logic en, input logic [31:0] data);
    if (en) begin
      gate_data = data;
    end else begin
      gate_data = 32'h0000_0000;
    end
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_req_reg.sv
// Request register for the memory bus arbiter: holds the winner's address,
// write data and control fields for the whole grant, loaded only on a new grant.
module arb_req_reg #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [A_WIDTH-1:0] nxt_a,
  input  logic [31:0]        nxt_wdata,
  input  logic [3:0]         nxt_wen,
  input  logic [1:0]         nxt_size,
  input  logic               nxt_rw,
  output logic [A_WIDTH-1:0] req_a,
  output logic [31:0]        req_wdata,
  output logic [3:0]         req_wen,
  output logic [1:0]         req_size,
  output logic               req_rw
);

  // Capture the granted request; contents persist through IDLE so the bus holds its last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_a     <= {A_WIDTH{1'b0}};
      req_wdata <= 32'h0000_0000;
      req_wen   <= 4'b0000;
      req_size  <= 2'b00;
      req_rw    <= 1'b0;
    end else if (load) begin
      req_a     <= nxt_a;
      req_wdata <= nxt_wdata;
      req_wen   <= nxt_wen;
      req_size  <= nxt_size;
      req_rw    <= nxt_rw;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single memory bus.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise data always wins a tie.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic               i_strobe,
  output logic [31:0]        i_din,
  output logic               i_ready,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_dout,
  input  logic [3:0]         d_wen,
  input  logic [1:0]         d_size,
  input  logic               d_rw,
  input  logic               d_strobe,
  output logic [31:0]        d_din,
  output logic               d_ready,
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_din,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  output logic               m_rw,
  output logic               m_strobe,
  input  logic [31:0]        m_dout,
  input  logic               m_ready
);

  arb_state_e         state_r;
  arb_state_e         state_s;
  logic               load_s;
  logic               sel_d_s;
  logic               prefer_i_s;
  logic               i_ready_s;
  logic               d_ready_s;
  logic [A_WIDTH-1:0] nxt_a_s;
  logic [31:0]        nxt_wdata_s;
  logic [3:0]         nxt_wen_s;
  logic [1:0]         nxt_size_s;
  logic               nxt_rw_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_r;
  logic done_s;

  assign done_s = ((state_r == GRANT_I) || (state_r == GRANT_D)) && m_ready;

  // Remember who finished last so the other side wins the next tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GRANT_SIDE_I;
    end else if (done_s) begin
      last_grant_r <= (state_r == GRANT_D) ? GRANT_SIDE_D : GRANT_SIDE_I;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign prefer_i_s = (last_grant_r == GRANT_SIDE_D);
`else
  assign prefer_i_s = 1'b0;
`endif

  // State register; reset abandons any grant in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: arbitrate only from IDLE, and a grant runs until m_ready.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    sel_d_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_strobe || d_strobe) begin
          load_s  = 1'b1;
          sel_d_s = pick_data(i_strobe, d_strobe, prefer_i_s);
          state_s = sel_d_s ? GRANT_D : GRANT_I;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (m_ready) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Select the winning side's request fields for capture.
  always_comb begin
    nxt_a_s     = i_a;
    nxt_wdata_s = 32'h0000_0000;
    nxt_wen_s   = I_WEN;
    nxt_size_s  = I_SIZE;
    nxt_rw_s    = I_RW;
    if (sel_d_s) begin
      nxt_a_s     = d_a;
      nxt_wdata_s = d_dout;
      nxt_wen_s   = d_wen;
      nxt_size_s  = d_size;
      nxt_rw_s    = d_rw;
    end else begin
      nxt_a_s     = i_a;
    end
  end

  arb_req_reg #(
    .A_WIDTH (A_WIDTH)
  ) u_req_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .nxt_a     (nxt_a_s),
    .nxt_wdata (nxt_wdata_s),
    .nxt_wen   (nxt_wen_s),
    .nxt_size  (nxt_size_s),
    .nxt_rw    (nxt_rw_s),
    .req_a     (m_a),
    .req_wdata (m_din),
    .req_wen   (m_wen),
    .req_size  (m_size),
    .req_rw    (m_rw)
  );

  // A requester that dropped its strobe, or a reset in flight, gets no ready pulse.
  assign i_ready_s = (state_r == GRANT_I) && m_ready && i_strobe && !rst;
  assign d_ready_s = (state_r == GRANT_D) && m_ready && d_strobe && !rst;

  assign m_strobe = (state_r == GRANT_I) || (state_r == GRANT_D);
  assign i_ready  = i_ready_s;
  assign d_ready  = d_ready_s;
  assign i_din    = gate_data(i_ready_s, m_dout);
  assign d_din    = gate_data(d_ready_s, m_dout);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model (honours ARB_ROUND_ROBIN_EN).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_a;
  logic        i_strobe;
  logic [31:0] i_din;
  logic        i_ready;
  logic [31:0] d_a;
  logic [31:0] d_dout;
  logic [3:0]  d_wen;
  logic [1:0]  d_size;
  logic        d_rw;
  logic        d_strobe;
  logic [31:0] d_din;
  logic        d_ready;
  logic [31:0] m_a;
  logic [31:0] m_din;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;
  logic        m_rw;
  logic        m_strobe;
  logic [31:0] m_dout;
  logic        m_ready;

  int n_total = 0;
  int n_pass  = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_bus_arbiter #(.A_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_a(i_a), .i_strobe(i_strobe), .i_din(i_din), .i_ready(i_ready),
    .d_a(d_a), .d_dout(d_dout), .d_wen(d_wen), .d_size(d_size), .d_rw(d_rw),
    .d_strobe(d_strobe), .d_din(d_din), .d_ready(d_ready),
    .m_a(m_a), .m_din(m_din), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
    .m_strobe(m_strobe), .m_dout(m_dout), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_a = 32'h0; i_strobe = 1'b0;
    d_a = 32'h0; d_dout = 32'h0; d_wen = 4'h0; d_size = 2'b00; d_rw = 1'b0; d_strobe = 1'b0;
    m_dout = 32'h0; m_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); idle_inputs(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); rst = 1'b1; m_ready = 1'b1; m_dout = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    n_total++;
    if ({m_strobe, i_ready, d_ready, i_din, d_din} !== {3'b000, 32'h0, 32'h0})
      $display("FAIL reset_ctrl: got %h expected 0", {m_strobe, i_ready, d_ready, i_din, d_din});
    else n_pass++;
    n_total++;
    if ({m_a, m_din, m_wen, m_size, m_rw} !== {32'h0, 32'h0, 4'h0, 2'b00, 1'b0})
      $display("FAIL reset_reqregs: got %h expected 0", {m_a, m_din, m_wen, m_size, m_rw});
    else n_pass++;
    rst = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_instr_only();
    @(negedge clk); idle_inputs(); i_strobe = 1'b1; i_a = 32'h1FC0_0000; #1;
    n_total++;
    if (m_strobe !== 1'b0) $display("FAIL instr_grant_delay: m_strobe=%b expected 0", m_strobe);
    else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); m_ready = (c == 3); m_dout = 32'h2402_0001; #1;
      n_total++;
      if ({m_strobe, m_a, m_rw, m_wen, m_size} !== {1'b1, 32'h1FC0_0000, 1'b0, 4'b0000, 2'b10})
        $display("FAIL instr_bus c%0d: got %h expected %h", c, {m_strobe, m_a, m_rw, m_wen, m_size},
                 {1'b1, 32'h1FC0_0000, 1'b0, 4'b0000, 2'b10});
      else n_pass++;
      n_total++;
      if ({i_ready, i_din, d_ready} !== ((c == 3) ? {1'b1, 32'h2402_0001, 1'b0} : {1'b0, 32'h0, 1'b0}))
        $display("FAIL instr_ready c%0d: got %h", c, {i_ready, i_din, d_ready});
      else n_pass++;
    end
    @(negedge clk); m_ready = 1'b0; i_strobe = 1'b0; #1;
    n_total++;
    if ({m_strobe, i_ready, i_din, m_a} !== {1'b0, 1'b0, 32'h0, 32'h1FC0_0000})
      $display("FAIL instr_after: got %h expected %h", {m_strobe, i_ready, i_din, m_a},
               {1'b0, 1'b0, 32'h0, 32'h1FC0_0000});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    @(negedge clk); idle_inputs(); i_strobe = 1'b1; d_strobe = 1'b1;
    d_a = 32'h0000_0100; i_a = 32'h0000_0200; #1;
    n_total++;
    if (m_strobe !== 1'b0) $display("FAIL sim_idle0: m_strobe=%b expected 0", m_strobe);
    else n_pass++;
    @(negedge clk); m_ready = 1'b1; m_dout = 32'hAAAA_0001; #1;
    n_total++;
    if ({m_strobe, m_a, d_ready, d_din, i_ready, i_din} !== {1'b1, 32'h100, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0})
      $display("FAIL sim_data_first: got %h", {m_strobe, m_a, d_ready, d_din, i_ready, i_din});
    else n_pass++;
    @(negedge clk); m_ready = 1'b0; d_strobe = 1'b0; #1;
    n_total++;
    if ({m_strobe, i_ready, d_ready} !== 3'b000)
      $display("FAIL sim_idle_gap: got %b expected 000", {m_strobe, i_ready, d_ready});
    else n_pass++;
    @(negedge clk); m_ready = 1'b1; m_dout = 32'h5555_0002; #1;
    n_total++;
    if ({m_strobe, m_a, m_rw, i_ready, i_din, d_ready} !== {1'b1, 32'h200, 1'b0, 1'b1, 32'h5555_0002, 1'b0})
      $display("FAIL sim_instr_second: got %h", {m_strobe, m_a, m_rw, i_ready, i_din, d_ready});
    else n_pass++;
    @(negedge clk); idle_inputs(); #1;
    n_total++;
    if (m_strobe !== 1'b0) $display("FAIL sim_end: m_strobe=%b expected 0", m_strobe);
    else n_pass++;
  endtask

  task automatic test_write();
    @(negedge clk); idle_inputs(); d_strobe = 1'b1; d_rw = 1'b1; d_wen = 4'b0011;
    d_dout = 32'hDEAD_BEEF; d_size = 2'b01; d_a = 32'h0000_1000;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        d_a = 32'h0BAD_0000; d_dout = 32'h0; d_wen = 4'b1100; d_size = 2'b10; d_rw = 1'b0;
      end else begin
        d_rw = d_rw;
      end
      m_ready = (c == 3); m_dout = 32'h1234_5678; #1;
      n_total++;
      if ({m_strobe, m_a, m_rw, m_wen, m_din, m_size} !== {1'b1, 32'h1000, 1'b1, 4'b0011, 32'hDEAD_BEEF, 2'b01})
        $display("FAIL write_hold c%0d: got %h", c, {m_strobe, m_a, m_rw, m_wen, m_din, m_size});
      else n_pass++;
      n_total++;
      if ({d_ready, d_din, i_ready} !== ((c == 3) ? {1'b1, 32'h1234_5678, 1'b0} : {1'b0, 32'h0, 1'b0}))
        $display("FAIL write_ready c%0d: got %h", c, {d_ready, d_din, i_ready});
      else n_pass++;
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_strobe_drop();
    @(negedge clk); idle_inputs(); i_strobe = 1'b1; i_a = 32'h0000_0040;
    @(negedge clk); i_strobe = 1'b0; #1;
    n_total++;
    if ({m_strobe, m_a} !== {1'b1, 32'h40}) $display("FAIL drop_grant: got %h", {m_strobe, m_a});
    else n_pass++;
    @(negedge clk); m_ready = 1'b1; m_dout = 32'hFFFF_FFFF; d_strobe = 1'b1; d_a = 32'h0000_0088; #1;
    n_total++;
    if ({m_strobe, i_ready, i_din, d_ready, d_din} !== {1'b1, 1'b0, 32'h0, 1'b0, 32'h0})
      $display("FAIL drop_no_ready: got %h", {m_strobe, i_ready, i_din, d_ready, d_din});
    else n_pass++;
    @(negedge clk); m_ready = 1'b0; #1;
    n_total++;
    if (m_strobe !== 1'b0) $display("FAIL drop_completes: m_strobe=%b expected 0", m_strobe);
    else n_pass++;
    @(negedge clk); m_ready = 1'b1; m_dout = 32'h0000_00D5; #1;
    n_total++;
    if ({m_strobe, m_a, d_ready, d_din} !== {1'b1, 32'h88, 1'b1, 32'hD5})
      $display("FAIL drop_late_strobe: got %h", {m_strobe, m_a, d_ready, d_din});
    else n_pass++;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset_mid_grant();
    @(negedge clk); idle_inputs(); d_strobe = 1'b1; d_a = 32'h0000_0080;
    @(negedge clk); rst = 1'b1; m_ready = 1'b1; m_dout = 32'h0000_0077; #1;
    n_total++;
    if ({d_ready, d_din, i_ready} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL rstmid_no_ready: got %h", {d_ready, d_din, i_ready});
    else n_pass++;
    @(negedge clk); rst = 1'b0; d_strobe = 1'b0; m_ready = 1'b0; #1;
    n_total++;
    if ({m_strobe, m_a, d_ready} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL rstmid_idle: got %h", {m_strobe, m_a, d_ready});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int got_side[4];
    int got_cyc[4];
    int n_got;
    int exp_side;
    n_got = 0;
    apply_reset();
    @(negedge clk); i_strobe = 1'b1; d_strobe = 1'b1; i_a = 32'h10; d_a = 32'h20; m_ready = 1'b1;
    for (int c = 0; c < 16 && n_got < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (d_ready || i_ready) begin
        got_side[n_got] = d_ready ? 2 : 1;
        got_cyc[n_got]  = c;
        n_got++;
      end else begin
        n_got = n_got;
      end
    end
    n_total++;
    if (n_got != 4) $display("FAIL b2b_count: got %0d grants expected 4", n_got);
    else n_pass++;
    for (int k = 0; k < n_got; k++) begin
      exp_side = (RR && (k % 2 == 1)) ? 1 : 2;
      n_total++;
      if (got_side[k] != exp_side || got_cyc[k] != 2 * k + 1)
        $display("FAIL b2b_order k%0d: side %0d cycle %0d expected side %0d cycle %0d",
                 k, got_side[k], got_cyc[k], exp_side, 2 * k + 1);
      else n_pass++;
    end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_random();
    int          owner;   // 0 none, 1 instruction, 2 data
    bit          last_d;
    bit          take_d;
    logic [31:0] e_a, e_din;
    logic [3:0]  e_wen;
    logic [1:0]  e_size;
    logic        e_rw, e_ir, e_dr;
    apply_reset();
    owner = 0; last_d = 1'b0; e_a = 32'h0; e_din = 32'h0; e_wen = 4'h0; e_size = 2'b00; e_rw = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      i_strobe = 1'($urandom_range(0, 1)); d_strobe = 1'($urandom_range(0, 1));
      i_a = $urandom; d_a = $urandom; d_dout = $urandom;
      d_wen = 4'($urandom_range(0, 15)); d_size = 2'($urandom_range(0, 3)); d_rw = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 2) == 0); m_dout = $urandom;
      #1;
      e_ir = (owner == 1) && m_ready && i_strobe && !rst;
      e_dr = (owner == 2) && m_ready && d_strobe && !rst;
      n_total++;
      if ({i_ready, d_ready, i_din, d_din, m_strobe, m_a, m_din, m_wen, m_size, m_rw} !==
          {e_ir, e_dr, (e_ir ? m_dout : 32'h0), (e_dr ? m_dout : 32'h0), (owner != 0),
           e_a, e_din, e_wen, e_size, e_rw})
        $display("FAIL random c%0d: got %h expected %h", c,
                 {i_ready, d_ready, i_din, d_din, m_strobe, m_a, m_din, m_wen, m_size, m_rw},
                 {e_ir, e_dr, (e_ir ? m_dout : 32'h0), (e_dr ? m_dout : 32'h0), (owner != 0),
                  e_a, e_din, e_wen, e_size, e_rw});
      else n_pass++;
      if (rst) begin
        owner = 0; last_d = 1'b0;
        e_a = 32'h0; e_din = 32'h0; e_wen = 4'h0; e_size = 2'b00; e_rw = 1'b0;
      end else if (owner == 0) begin
        if (i_strobe || d_strobe) begin
          take_d = d_strobe && !(i_strobe && RR && last_d);
          if (take_d) begin
            owner = 2; e_a = d_a; e_din = d_dout; e_wen = d_wen; e_size = d_size; e_rw = d_rw;
          end else begin
            owner = 1; e_a = i_a; e_din = 32'h0; e_wen = 4'b0000; e_size = 2'b10; e_rw = 1'b0;
          end
        end else begin
          owner = 0;
        end
      end else if (m_ready) begin
        last_d = (owner == 2);
        owner = 0;
      end else begin
        owner = owner;
      end
    end
    @(negedge clk); idle_inputs(); rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_instr_only();
    test_simultaneous();
    test_write();
    test_strobe_drop();
    test_reset_mid_grant();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
